// File: rtl/fifo_same_clock_level.sv
// Single-clock first-word-fall-through FIFO with registered level flags.
// Ports: clk, rst_n (sync, active-low), we/data_in, re/data_out, nempty,
// full, almost_full, almost_empty, half_empty, fill, overflow, underflow.
// Optional sticky error flags when FIFO_SAME_CLOCK_ERR_FLAGS_EN is defined.
module fifo_same_clock_level #(
  parameter int DATA_WIDTH   = 16,
  parameter int DATA_DEPTH   = 4,
  parameter int AFULL_LEVEL  = 12,
  parameter int AEMPTY_LEVEL = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic                  re,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  nempty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  half_empty,
  output logic [DATA_DEPTH:0]   fill,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** DATA_DEPTH;
  localparam int HALF  = 2 ** (DATA_DEPTH - 1);

  typedef logic [DATA_DEPTH:0]   cnt_t;
  typedef logic [DATA_DEPTH-1:0] adr_t;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  adr_t waddr_q, waddr_d;
  adr_t raddr_q, raddr_d;
  cnt_t fill_q, fill_d;
  logic nempty_q, nempty_d;
  logic full_q, full_d;
  logic afull_q, afull_d;
  logic aempty_q, aempty_d;
  logic half_q, half_d;
  logic wr_acc, rd_acc;

  always_comb begin
    wr_acc  = we && !full_q;
    rd_acc  = re && nempty_q;
    waddr_d = waddr_q + adr_t'(wr_acc);
    raddr_d = raddr_q + adr_t'(rd_acc);
    fill_d  = fill_q;
    unique case (1'b1)
      wr_acc && !rd_acc: fill_d = fill_q + cnt_t'(1);
      !wr_acc && rd_acc: fill_d = fill_q - cnt_t'(1);
      default: ;
    endcase
    // Flags come from the next count so they line up with fill.
    nempty_d = fill_d != '0;
    full_d   = fill_d == cnt_t'(DEPTH);
    afull_d  = int'(fill_d) >= AFULL_LEVEL;
    aempty_d = int'(fill_d) <= AEMPTY_LEVEL;
    half_d   = int'(fill_d) <= HALF;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      waddr_q  <= '0;
      raddr_q  <= '0;
      fill_q   <= '0;
      nempty_q <= 1'b0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      half_q   <= 1'b1;
    end else begin
      waddr_q  <= waddr_d;
      raddr_q  <= raddr_d;
      fill_q   <= fill_d;
      nempty_q <= nempty_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      half_q   <= half_d;
    end
  end

  // Storage is never cleared; reset only rewinds the pointers.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) mem_q[waddr_q] <= data_in;
  end

`ifdef FIFO_SAME_CLOCK_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  always_comb begin
    // A write while full is only an error if no read frees a slot.
    ovf_d = ovf_q | (we && full_q && !rd_acc);
    udf_d = udf_q | (re && !nempty_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign data_out     = mem_q[raddr_q];
  assign nempty       = nempty_q;
  assign full         = full_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign half_empty   = half_q;
  assign fill         = fill_q;

endmodule

// File: tb/tb_fifo_same_clock_level.sv
// Scoreboard bench for fifo_same_clock_level (default parameters).
// Reads are checked by a monitor against words queued at write time.
module tb_fifo_same_clock_level;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic        re;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        nempty;
  logic        full;
  logic        almost_full;
  logic        almost_empty;
  logic        half_empty;
  logic [4:0]  fill;
  logic        overflow;
  logic        underflow;

  fifo_same_clock_level dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .we           (we),
    .re           (re),
    .data_in      (data_in),
    .data_out     (data_out),
    .nempty       (nempty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .half_empty   (half_empty),
    .fill         (fill),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  int checks   = 0;
  int failures = 0;

  logic [15:0] sb[$];
  int   m_fill;
  logic m_ovf;
  logic m_udf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a read is accepted at the next edge when re && nempty.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && re === 1'b1 && nempty === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected: got %0h expected none", data_out);
      end else begin
        chk("rd_data", {16'h0, data_out}, {16'h0, sb.pop_front()});
      end
    end
  end

  task automatic check_state();
    logic eo, eu;
`ifdef FIFO_SAME_CLOCK_ERR_FLAGS_EN
    eo = m_ovf;
    eu = m_udf;
`else
    eo = 1'b0;
    eu = 1'b0;
`endif
    chk("fill", {27'h0, fill}, m_fill);
    chk("flags",
        {25'h0, nempty, full, almost_full, almost_empty,
         half_empty, overflow, underflow},
        {25'h0, m_fill != 0, m_fill == 16, m_fill >= 12,
         m_fill <= 4, m_fill <= 8, eo, eu});
  endtask

  task automatic cyc(input logic w, input logic r, input logic [15:0] d);
    logic wa, ra;
    we      = w;
    re      = r;
    data_in = d;
    wa = w && (m_fill != 16);
    ra = r && (m_fill != 0);
    if (wa) sb.push_back(d);
    if (w && m_fill == 16 && !ra) m_ovf = 1'b1;
    if (r && m_fill == 0) m_udf = 1'b1;
    m_fill = m_fill + int'(wa) - int'(ra);
    @(posedge clk);
    #1;
    we = 1'b0;
    re = 1'b0;
    check_state();
  endtask

  // we/re held high during reset to show they are ignored.
  task automatic do_reset();
    rst_n   = 1'b0;
    we      = 1'b1;
    re      = 1'b1;
    data_in = 16'hFFFF;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    we     = 1'b0;
    re     = 1'b0;
    sb.delete();
    m_fill = 0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    check_state();
  endtask

  task automatic drain();
    while (m_fill > 0) cyc(1'b0, 1'b1, 16'h0);
  endtask

  initial begin
    logic [15:0] v;
    int wr_cnt;
    rst_n   = 1'b0;
    we      = 1'b0;
    re      = 1'b0;
    data_in = 16'h0;
    m_fill  = 0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Fill with 1..16, head must be the first word.
    for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b0, 16'(i));
    chk("head_after_fill", {16'h0, data_out}, 32'h0001);

    // Write while full is dropped.
    cyc(1'b1, 1'b0, 16'hDEAD);
    drain();

    // Empty: simultaneous we && re takes only the write.
    cyc(1'b1, 1'b1, 16'h00AA);
    chk("fwft_aa", {16'h0, data_out}, 32'h00AA);
    drain();

    // Full: simultaneous we && re takes only the read.
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 16'h0200 + 16'(i));
    cyc(1'b1, 1'b1, 16'hBEEF);
    drain();

    // Stream 40 words, fill oscillating across the 8/9 boundary.
    v = 16'h0100;
    wr_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, v);
      v++;
      wr_cnt++;
    end
    for (int i = 0; wr_cnt < 40 && i < 400; i++) begin
      logic w, r;
      if ((i % 20) < 10) begin
        w = 1'b1;
        r = (i % 2) == 1;
      end else begin
        w = (i % 2) == 1;
        r = 1'b1;
      end
      if (m_fill >= 15) w = 1'b0;
      if (m_fill <= 1) r = 1'b0;
      cyc(w, r, v);
      if (w) begin
        v++;
        wr_cnt++;
      end
    end
    chk("stream_words", wr_cnt, 40);
    drain();

    // Read while empty (underflow when enabled), then reset at fill 9.
    cyc(1'b0, 1'b1, 16'h0);
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 16'h0300 + 16'(i));
    do_reset();

    // Operation after reset still works.
    cyc(1'b1, 1'b0, 16'h0777);
    chk("fwft_777", {16'h0, data_out}, 32'h0777);
    drain();

    repeat (2) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_same_clock_level.md
FIFO_SAME_CLOCK_LEVEL -- requirements
Module: fifo_same_clock_level

Interface
REQ-001 Parameter DATA_WIDTH, default 16: data bits per word.
REQ-002 Parameter DATA_DEPTH, default 4: log2 of storage words (depth = 2**DATA_DEPTH), legal range 2..12.
REQ-003 Parameter AFULL_LEVEL, default 12: almost_full asserts when fill >= AFULL_LEVEL.
REQ-004 Parameter AEMPTY_LEVEL, default 4: almost_empty asserts when fill <= AEMPTY_LEVEL.
REQ-005 Port clk  input  1: single clock, positive edge; one clock; reset is synchronous and active-low.
REQ-006 Port rst_n  input  1: synchronous active-low reset, sampled on rising clk.
REQ-007 Port we  input  1: write request.
REQ-008 Port re  input  1: read request (acknowledges current data_out).
REQ-009 Port data_in  input  DATA_WIDTH: write data.
REQ-010 Port data_out  output  DATA_WIDTH: head-of-FIFO word, first-word-fall-through.
REQ-011 Port nempty  output  1: FIFO holds >= 1 word.
REQ-012 Port full  output  1: FIFO holds 2**DATA_DEPTH words.
REQ-013 Port almost_full / almost_empty / half_empty  output  1 each: level flags.
REQ-014 Port fill  output  DATA_DEPTH+1: current word count.
REQ-015 Port overflow / underflow  output  1 each: error flags (see Configuration).

Function
REQ-016 Write accepted iff we && !full (full sampled before the edge); word stored at waddr, waddr increments modulo 2**DATA_DEPTH.
REQ-017 Read accepted iff re && nempty; raddr increments modulo 2**DATA_DEPTH.
REQ-018 data_out = storage[raddr] combinationally; written word visible on data_out the cycle after its write edge; undefined when nempty=0.
REQ-019 fill: +1 on write-only, -1 on read-only, unchanged on both or neither; never exceeds 2**DATA_DEPTH or goes below 0.
REQ-020 Simultaneous we && re when full: read accepted, write rejected, fill decrements to depth-1.
REQ-021 Simultaneous we && re when empty: write accepted, read ignored, fill becomes 1.
REQ-022 All flags registered, updated same edge as fill, derived from next fill value: nempty=(fill!=0), full=(fill==2**DATA_DEPTH), half_empty=(fill<=2**(DATA_DEPTH-1)), exact (no Gray-code uncertainty).
REQ-023 Address wrap-around transparent: no data loss or flag glitch across raddr/waddr rollover.

Reset
REQ-024 While rst_n=0 at a rising clk: waddr=raddr=0, fill=0, nempty=0, full=0, almost_full=0, almost_empty=1, half_empty=1, overflow=underflow=0.
REQ-025 Reset mid-operation discards all stored words; storage array not cleared; we/re ignored on reset cycles.

Configuration
REQ-026 Macro FIFO_SAME_CLOCK_ERR_FLAGS_EN defined: overflow sets (sticky) on we && full without concurrent accepted read... rejected write; underflow sets (sticky) on re && !nempty; both clear only by reset.
REQ-027 Macro undefined: overflow and underflow tied to 0; no error logic synthesised.

Verification
REQ-028 Reset then 16 writes 0x0001..0x0010 (DATA_DEPTH=4) -> fill=16, full=1, almost_full=1 after write 12, data_out=0x0001.
REQ-029 From full, 17th write of 0xDEAD -> fill stays 16, then 16 reads return 0x0001..0x0010 in order, nempty=0 after last; overflow=1 only with macro.
REQ-030 Empty FIFO, we&&re same cycle with 0x00AA -> fill=1, data_out=0x00AA next cycle; underflow=0.
REQ-031 Full FIFO, we&&re same cycle -> fill=15, full=0, rejected word never appears on data_out.
REQ-032 Stream 40 words with random we/re keeping fill 1..15 -> output order matches input across two raddr wraps; half_empty toggles exactly at fill 8/9.
REQ-033 rst_n low for one cycle with fill=9 -> next cycle fill=0, nempty=0, almost_empty=1, sticky flags cleared.
